// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: oversampled UART receiver -> byte FIFO -> UART transmitter that echoes bytes in order.
// Define UART_PARITY_EN to add an even-parity bit to both directions (checked on receive).
`timescale 1ns/1ps
module uart_echo_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx,
  output logic                             tx,
  input  logic                             echo_en,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             tx_busy,
  output logic                             overflow,
  output logic                             frame_err,
  output logic                             parity_err
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam state_t AFTER_DATA = S_PARITY;

  function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam state_t AFTER_DATA = S_STOP;
`endif

  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 tick_s;
  logic                 rx_meta_q, rx_sync_q;
  state_t               rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [OW-1:0]        rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        rx_bits_q, rx_bits_d, tx_bits_q, tx_bits_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic                 push_q, push_d, frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic                 tx_q, tx_d, tx_busy_q, tx_busy_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 pop_s, accept_s;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d, tx_par_q, tx_par_d, parity_err_q, parity_err_d;
`endif

  always_comb begin : tick_gen
    tick_s = (tcnt_q == TICK_LAST);
    if (tick_s) tcnt_d = '0;
    else        tcnt_d = tcnt_q + 1'b1;
  end

  always_comb begin : rx_next
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bits_d   = rx_bits_q;
    rx_shift_d  = rx_shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d     = rx_par_q;
    parity_err_d = 1'b0;
`endif
    case (rx_state_q)
      S_IDLE: begin
        if (tick_s && !rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      // A start bit that is high again at mid-bit is a glitch and is ignored silently.
      S_START: begin
        if (tick_s && (rx_cnt_q == OS_HALF)) begin
          rx_cnt_d   = '0;
          rx_bits_d  = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else if (tick_s) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q;
        end
      end
      default: begin
        if (tick_s && (rx_cnt_q == OS_LAST)) begin
          rx_cnt_d = '0;
          case (rx_state_q)
            S_DATA: begin
              rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bits_q == BIT_LAST) rx_state_d = AFTER_DATA;
              else                       rx_bits_d  = rx_bits_q + 1'b1;
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
              rx_par_d   = rx_sync_q;
              rx_state_d = S_STOP;
            end
`endif
            S_STOP: begin
              rx_state_d = S_IDLE;
              if (!rx_sync_q) frame_err_d = 1'b1;
`ifdef UART_PARITY_EN
              else if (rx_par_q != parity_f(rx_shift_q)) parity_err_d = 1'b1;
`endif
              else push_d = 1'b1;
            end
            default: rx_state_d = S_IDLE;
          endcase
        end else if (tick_s) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q;
        end
      end
    endcase
  end

  // A push onto a full FIFO is only accepted when the same clock frees a slot.
  always_comb begin : fifo_next
    pop_s      = (tx_state_q == S_IDLE) && echo_en && (count_q != '0);
    accept_s   = push_q && ((count_q != FULL) || pop_s);
    overflow_d = push_q && !accept_s;
    wptr_d     = accept_s ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop_s ? rptr_q + 1'b1 : rptr_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin : tx_next
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      S_IDLE: begin
        if (pop_s) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_shift_d = mem_q[rptr_q];
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
`ifdef UART_PARITY_EN
          tx_par_d   = parity_f(mem_q[rptr_q]);
`endif
        end else begin
          tx_d      = 1'b1;
          tx_busy_d = 1'b0;
        end
      end
      default: begin
        if (tick_s && (tx_cnt_q == OS_LAST)) begin
          tx_cnt_d = '0;
          case (tx_state_q)
            S_START: begin
              tx_state_d = S_DATA;
              tx_bits_d  = '0;
              tx_d       = tx_shift_q[0];
              tx_shift_d = tx_shift_q >> 1;
            end
            S_DATA: begin
              if (tx_bits_q == BIT_LAST) begin
                tx_state_d = AFTER_DATA;
`ifdef UART_PARITY_EN
                tx_d = tx_par_q;
`else
                tx_d = 1'b1;
`endif
              end else begin
                tx_bits_d  = tx_bits_q + 1'b1;
                tx_d       = tx_shift_q[0];
                tx_shift_d = tx_shift_q >> 1;
              end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
              tx_state_d = S_STOP;
              tx_d       = 1'b1;
            end
`endif
            S_STOP: begin
              tx_state_d = S_IDLE;
              tx_busy_d  = 1'b0;
              tx_d       = 1'b1;
            end
            default: tx_state_d = S_IDLE;
          endcase
        end else if (tick_s) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin : state_regs
    if (rst) begin
      tcnt_q <= '0;  rx_meta_q <= 1'b1;  rx_sync_q <= 1'b1;
      rx_state_q <= S_IDLE;  rx_cnt_q <= '0;  rx_bits_q <= '0;  rx_shift_q <= '0;
      push_q <= 1'b0;  frame_err_q <= 1'b0;  overflow_q <= 1'b0;
      wptr_q <= '0;  rptr_q <= '0;  count_q <= '0;
      tx_state_q <= S_IDLE;  tx_cnt_q <= '0;  tx_bits_q <= '0;  tx_shift_q <= '0;
      tx_q <= 1'b1;  tx_busy_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q <= 1'b0;  tx_par_q <= 1'b0;  parity_err_q <= 1'b0;
`endif
    end else begin
      tcnt_q <= tcnt_d;  rx_meta_q <= rx;  rx_sync_q <= rx_meta_q;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_bits_q <= rx_bits_d;  rx_shift_q <= rx_shift_d;
      push_q <= push_d;  frame_err_q <= frame_err_d;  overflow_q <= overflow_d;
      wptr_q <= wptr_d;  rptr_q <= rptr_d;  count_q <= count_d;
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_bits_q <= tx_bits_d;  tx_shift_q <= tx_shift_d;
      tx_q <= tx_d;  tx_busy_q <= tx_busy_d;
`ifdef UART_PARITY_EN
      rx_par_q <= rx_par_d;  tx_par_q <= tx_par_d;  parity_err_q <= parity_err_d;
`endif
    end
  end

  // Receive shift register stays stable until the next frame's data bits, so it feeds the write directly.
  always_ff @(posedge clk) begin : fifo_mem
    if (!rst && accept_s) mem_q[wptr_q] <= rx_shift_q;
  end

  assign tx         = tx_q;
  assign tx_busy    = tx_busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo at 1.6 MHz / 10 kbaud (160 clk per bit), depth 16, 8 data bits.
`timescale 1ns/1ps
module tb_uart_echo_fifo;
  localparam int BIT = 160;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LEN_HI = BIT * NB;
  localparam int LEN_LO = LEN_HI - 9;

  logic clk, rst, rx, tx, echo_en, tx_busy, overflow, frame_err, parity_err;
  logic [4:0] fifo_count;
  int n_vec = 0, n_bad = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic [NB-1:0] frames[$];
  int lens[$];
`ifdef UART_PARITY_EN
  logic par_use_force = 1'b0, par_force = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic       echo;
    int         fe;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[4];

  uart_echo_fifo #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .echo_en(echo_en), .fifo_count(fifo_count),
    .tx_busy(tx_busy), .overflow(overflow), .frame_err(frame_err), .parity_err(parity_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)  fe_cnt++;
      if (overflow)   ov_cnt++;
      if (parity_err) pe_cnt++;
    end
  end

  // Line decoder: samples each tx bit at its centre and times the frame up to tx_busy falling.
  initial begin : tx_decoder
    logic [NB-1:0] f;
    int len;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        repeat (BIT/2) @(negedge clk);
        f[0] = tx;
        for (int b = 1; b < NB; b++) begin
          repeat (BIT) @(negedge clk);
          f[b] = tx;
        end
        len = BIT/2 + BIT*(NB-1);
        while (tx_busy && len < 4000) begin
          @(negedge clk);
          len++;
        end
        frames.push_back(f);
        lens.push_back(len);
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = par_use_force ? par_force : ^d;
    repeat (BIT) @(negedge clk);
`endif
    rx = stop_b;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    if (!stop_b) repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget, output logic ok);
    int t = 0;
    while (frames.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = (frames.size() >= n);
  endtask

  initial begin : main
    logic ok;
    int n0, fe0, ov0, pe0, low;
    logic [NB-1:0] exp_f, got_f;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0, 10'b1_10100101_0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1, 10'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 0, 10'b1_11111111_0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 0, 10'b1_00000001_0};

    rst = 1'b1; rx = 1'b1; echo_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_pulses", int'({overflow, frame_err, parity_err}), 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    echo_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n0 = frames.size(); fe0 = fe_cnt;
`ifdef UART_PARITY_EN
      exp_f = {1'b1, ^vecs[k].data, vecs[k].data, 1'b0};
`else
      exp_f = vecs[k].frame;
`endif
      send_byte(vecs[k].data, vecs[k].stop_b);
      if (vecs[k].echo) begin
        wait_frames(n0 + 1, 3000, ok);
        chk("echo_arrived", int'(ok), 1);
        if (ok) begin
          chk("echo_frame", int'(frames[n0]), int'(exp_f));
          chk("echo_len_in_range", int'(lens[n0] >= LEN_LO && lens[n0] <= LEN_HI), 1);
        end
      end else begin
        repeat (1800) @(negedge clk);
        chk("no_echo", frames.size(), n0);
      end
      chk("frame_err_pulses", fe_cnt - fe0, vecs[k].fe);
      chk("count_after_vec", int'(fifo_count), 0);
    end

    // Glitch: three ticks low must not start a frame.
    repeat (200) @(negedge clk);
    echo_en = 1'b0; fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_count", int'(fifo_count), 0);
    chk("glitch_pulses", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

    // Fill past capacity with echo disabled, then drain.
    ov0 = ov_cnt; n0 = frames.size();
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b1);
      if (i < 16) chk("fill_count", int'(fifo_count), i + 1);
    end
    chk("fill_count_full", int'(fifo_count), 16);
    chk("overflow_pulses", ov_cnt - ov0, 1);
    echo_en = 1'b1;
    wait_frames(n0 + 16, 30000, ok);
    chk("drain_arrived", int'(ok), 1);
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        got_f = frames[n0 + i];
        chk("drain_order", int'(got_f[8:1]), i);
      end
    end
    repeat (200) @(negedge clk);
    chk("drain_count", int'(fifo_count), 0);
    chk("drain_no_extra", frames.size(), n0 + 16);

`ifdef UART_PARITY_EN
    // 0x07 has odd weight, so even parity requires a 1.
    pe0 = pe_cnt; n0 = frames.size();
    par_use_force = 1'b1; par_force = 1'b0;
    send_byte(8'h07, 1'b1);
    repeat (1800) @(negedge clk);
    chk("par_bad_pulse", pe_cnt - pe0, 1);
    chk("par_bad_dropped", frames.size(), n0);
    par_force = 1'b1;
    send_byte(8'h07, 1'b1);
    wait_frames(n0 + 1, 3000, ok);
    chk("par_good_arrived", int'(ok), 1);
    if (ok) chk("par_good_frame", int'(frames[n0]), int'({1'b1, 1'b1, 8'h07, 1'b0}));
    par_use_force = 1'b0;
    repeat (200) @(negedge clk);
`endif

    // Reset in the middle of a transmission with three bytes still queued.
    echo_en = 1'b0;
    send_byte(8'h55, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    chk("pre_reset_count", int'(fifo_count), 4);
    echo_en = 1'b1;
    repeat (800) @(negedge clk);
    chk("pre_reset_busy", int'(tx_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_count", int'(fifo_count), 0);
    rst = 1'b0;
    low = 0;
    repeat (3000) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    chk("post_reset_tx_idle", low, 0);
    chk("post_reset_count", int'(fifo_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
